// File: rtl/inst_fetch_if.sv
// Fetch-side bus bundle: instruction-memory address/data, decode valid/ready
// handshake, redirect request, fault flag and a debug view of buffer occupancy.
interface inst_fetch_if;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_fetch_fault;
  logic [3:0]  dbg_count;

  // Handshake: a word transfers to decode on any rising edge where o_valid
  // and i_ready are both high with no redirect; o_instr/o_pc hold while
  // o_valid && !i_ready, and o_valid never depends on i_ready.
  modport master (
    output o_imem_addr, o_valid, o_instr, o_pc, o_fetch_fault, dbg_count,
    input  i_imem_data, i_ready, i_redirect_valid, i_redirect_pc
  );

  modport slave (
    input  o_imem_addr, o_valid, o_instr, o_pc, o_fetch_fault, dbg_count,
    output i_imem_data, i_ready, i_redirect_valid, i_redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, in-order {pc, instr} buffer, redirect flush.
// Optional INST_FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault.
module inst_fetch #(
  parameter logic [31:0] ResetPc  = 32'h0000_0000,
  parameter int          BufDepth = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  inst_fetch_if.master  bus
);
  localparam int PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(BufDepth);

  if (BufDepth < 2 || BufDepth > 8 || (BufDepth & (BufDepth - 1)) != 0) begin : g_bad_depth
    $error("inst_fetch: BufDepth must be a power of two in 2..8");
  end

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     buf_pc_q    [BufDepth];
  logic [31:0]     buf_instr_q [BufDepth];

  logic        pop;
  logic        push;
  logic        fault;
  logic [31:0] redirect_target;

`ifdef INST_FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Once set, only reset clears the fault; later redirects leave it alone.
  always_comb begin
    fault_d = fault_q;
    if (bus.i_redirect_valid && (bus.i_redirect_pc[1:0] != 2'b00)) fault_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign fault           = fault_q;
  assign redirect_target = bus.i_redirect_pc;
`else
  assign fault           = 1'b0;
  assign redirect_target = {bus.i_redirect_pc[31:2], 2'b00};
`endif

  assign pop  = (count_q != '0) && bus.i_ready;
  // Popping a full buffer frees its slot in the same cycle, so fetch keeps
  // streaming one word per cycle under continuous ready.
  assign push = !bus.i_redirect_valid && !fault && ((count_q < FullCnt) || pop);

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.i_redirect_valid) begin
      pc_d     = redirect_target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q     <= ResetPc;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries reset to zero so the head reads 0/0 straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BufDepth; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else if (push) begin
      buf_pc_q[wr_ptr_q]    <= pc_q;
      buf_instr_q[wr_ptr_q] <= bus.i_imem_data;
    end
  end

  assign bus.o_imem_addr   = pc_q;
  assign bus.o_valid       = (count_q != '0);
  assign bus.o_instr       = buf_instr_q[rd_ptr_q];
  assign bus.o_pc          = buf_pc_q[rd_ptr_q];
  assign bus.o_fetch_fault = fault;
  assign bus.dbg_count     = 4'(count_q);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stream, backpressure, full buffer, redirect,
// PC wrap, out-of-range memory and misaligned redirect.
module tb_inst_fetch;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  inst_fetch_if ifc ();

  inst_fetch #(
    .ResetPc  (32'h0000_0000),
    .BufDepth (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc.master)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 64 words, zero beyond, combinational read.
  always_comb begin
    ifc.i_imem_data = 32'h0;
    if (ifc.o_imem_addr == 32'h0)        ifc.i_imem_data = 32'h0000_0013;
    else if (ifc.o_imem_addr == 32'h4)   ifc.i_imem_data = 32'h0000_0093;
    else if (ifc.o_imem_addr == 32'h8)   ifc.i_imem_data = 32'h0000_0113;
    else if (ifc.o_imem_addr < 32'h100) ifc.i_imem_data = 32'hA000_0000 | ifc.o_imem_addr;
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    ifc.i_redirect_valid = 1'b1;
    ifc.i_redirect_pc    = tgt;
    cyc();
    ifc.i_redirect_valid = 1'b0;
    ifc.i_redirect_pc    = 32'h0;
  endtask

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, 32'(ifc.o_valid), 32'd1);
    check({tag, "_pc"},    ifc.o_pc,         pc);
    check({tag, "_instr"}, ifc.o_instr,      instr);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    ifc.i_ready          = 1'b1;
    ifc.i_redirect_valid = 1'b0;
    ifc.i_redirect_pc    = 32'h0;

    repeat (2) cyc();
    check("rst_valid", 32'(ifc.o_valid), 32'd0);
    check("rst_addr",  ifc.o_imem_addr,  32'h0);
    check("rst_instr", ifc.o_instr,      32'h0);
    check("rst_pc",    ifc.o_pc,         32'h0);
    check("rst_fault", 32'(ifc.o_fetch_fault), 32'd0);
    check("rst_count", 32'(ifc.dbg_count), 32'd0);

    // Streaming with ready held high
    rst_n = 1'b1;
    cyc();
    check_head("s0", 32'h0, 32'h13);
    check("s0_addr", ifc.o_imem_addr, 32'h4);
    cyc();
    check_head("s1", 32'h4, 32'h93);
    cyc();
    check_head("s2", 32'h8, 32'h113);
    check("s2_count", 32'(ifc.dbg_count), 32'd1);

    // Asynchronous reset mid-stream, no clock edge needed
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(ifc.o_valid), 32'd0);
    check("ar_addr",  ifc.o_imem_addr,  32'h0);
    check("ar_count", 32'(ifc.dbg_count), 32'd0);
    check("ar_pc",    ifc.o_pc,         32'h0);

    // Backpressure from reset: five cycles with ready low
    ifc.i_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("bp1_count", 32'(ifc.dbg_count), 32'd1);
    check("bp1_addr",  ifc.o_imem_addr,    32'h4);
    cyc();
    check("bp2_count", 32'(ifc.dbg_count), 32'd2);
    check("bp2_addr",  ifc.o_imem_addr,    32'h8);
    repeat (3) cyc();
    check("bp5_count", 32'(ifc.dbg_count), 32'd2);
    check("bp5_addr",  ifc.o_imem_addr,    32'h8);
    check_head("bp5", 32'h0, 32'h13);

    // Release: full buffer, push+pop every cycle, no gap or duplicate
    ifc.i_ready = 1'b1;
    cyc();
    check_head("f1", 32'h4, 32'h93);
    check("f1_count", 32'(ifc.dbg_count), 32'd2);
    cyc();
    check_head("f2", 32'h8, 32'h113);
    check("f2_count", 32'(ifc.dbg_count), 32'd2);
    cyc();
    check_head("f3", 32'hC, 32'hA000_000C);
    check("f3_count", 32'(ifc.dbg_count), 32'd2);
    cyc();
    check_head("f4", 32'h10, 32'hA000_0010);
    check("f4_count", 32'(ifc.dbg_count), 32'd2);
    check("f4_addr",  ifc.o_imem_addr,    32'h18);

    // Redirect while full and ready: old stream dropped
    redirect(32'h20);
    check("rd0_valid", 32'(ifc.o_valid), 32'd0);
    check("rd0_addr",  ifc.o_imem_addr,  32'h20);
    check("rd0_count", 32'(ifc.dbg_count), 32'd0);
    cyc();
    check_head("rd1", 32'h20, 32'hA000_0020);
    cyc();
    check_head("rd2", 32'h24, 32'hA000_0024);

    // PC wrap and read beyond memory size
    redirect(32'hFFFF_FFFC);
    check("wr0_addr", ifc.o_imem_addr, 32'hFFFF_FFFC);
    cyc();
    check_head("wr1", 32'hFFFF_FFFC, 32'h0);
    check("wr1_addr", ifc.o_imem_addr, 32'h0);
    cyc();
    check_head("wr2", 32'h0, 32'h13);

    // Misaligned redirect
    redirect(32'h22);
`ifdef INST_FETCH_ALIGN_CHECK_EN
    check("ma0_addr",  ifc.o_imem_addr,  32'h22);
    check("ma0_fault", 32'(ifc.o_fetch_fault), 32'd1);
    check("ma0_valid", 32'(ifc.o_valid), 32'd0);
    repeat (4) cyc();
    check("ma4_valid", 32'(ifc.o_valid), 32'd0);
    check("ma4_fault", 32'(ifc.o_fetch_fault), 32'd1);
    redirect(32'h40);
    cyc();
    check("ma_re_valid", 32'(ifc.o_valid), 32'd0);
    check("ma_re_fault", 32'(ifc.o_fetch_fault), 32'd1);
`else
    check("ma0_addr",  ifc.o_imem_addr,  32'h20);
    check("ma0_fault", 32'(ifc.o_fetch_fault), 32'd0);
    cyc();
    check_head("ma1", 32'h20, 32'hA000_0020);
    check("ma1_fault", 32'(ifc.o_fetch_fault), 32'd0);
`endif

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
